// File: rtl/nibble_entry_pkg.sv
// Shared definitions for the nibble entry front end: FSM state codes and default debounce length.
package nibble_entry_pkg;

  typedef enum logic [1:0] {
    StLow    = 2'd0,
    StHigh   = 2'd1,
    StCommit = 2'd2
  } state_e;

  localparam int unsigned DebounceCyclesDefault = 250000;

endpackage

// File: rtl/nibble_entry_debouncer.sv
// Button conditioner: 2-flop synchroniser, stability counter, registered rising-edge press pulse.
module nibble_entry_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  logic             meta_q, sync_q;
  logic             level_q, level_dly_q, press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q      <= 1'b0;
      sync_q      <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      meta_q      <= raw;
      sync_q      <= meta_q;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
      // Any return to the accepted level restarts the stability window.
      if (sync_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/nibble_entry.sv
// Operator nibble entry: debounced enter/clear buttons drive low/high nibble strobes to the
// byte shifter, then a byteReady pulse and a wrapping byte counter.
module nibble_entry
  import nibble_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] switches,
  input  logic       enter,
  input  logic       clear,
  output logic [3:0] nibbleData,
  output logic       down,
  output logic       up,
  output logic       byteReady,
  output logic [7:0] byteCount,
  output logic [3:0] debug
);

  logic       enter_level, enter_press;
  logic       clear_level, clear_press;
  logic [3:0] sw_meta_q, sw_sync_q;
  state_e     state_q;
  logic [3:0] nibble_q;
  logic       down_q, up_q, ready_q;
  logic [7:0] count_q;

  nibble_entry_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_enter_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (enter),
    .level(enter_level),
    .press(enter_press)
  );

  nibble_entry_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_clear_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (clear),
    .level(clear_level),
    .press(clear_press)
  );

  // Only the press pulses steer the FSM; levels are kept for observability.
  logic unused_levels;
  assign unused_levels = enter_level ^ clear_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StLow;
      nibble_q <= '0;
      down_q   <= 1'b0;
      up_q     <= 1'b0;
      ready_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      down_q  <= 1'b0;
      up_q    <= 1'b0;
      ready_q <= 1'b0;
      // Clear overrides everything, including a coincident enter or a pending commit.
      if (clear_press) begin
        state_q <= StLow;
      end else begin
        unique case (state_q)
          StLow: begin
            if (enter_press) begin
              nibble_q <= sw_sync_q;
              down_q   <= 1'b1;
              state_q  <= StHigh;
            end
          end
          StHigh: begin
            if (enter_press) begin
              nibble_q <= sw_sync_q;
              up_q     <= 1'b1;
              state_q  <= StCommit;
            end
          end
          StCommit: begin
            ready_q <= 1'b1;
            count_q <= count_q + 8'd1;
            state_q <= StLow;
          end
          default: state_q <= StLow;
        endcase
      end
    end
  end

  assign nibbleData = nibble_q;
  assign down       = down_q;
  assign up         = up_q;
  assign byteReady  = ready_q;
  assign byteCount  = count_q;
  assign debug      = {2'b00, state_q};

endmodule

// File: tb/tb_nibble_entry.sv
// Scoreboard bench for nibble_entry: stimulus pushes expected strobes, a negedge monitor pops them.
module tb_nibble_entry;

  localparam int unsigned Dc = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] switches = 4'h0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] nibbleData;
  logic       down, up, byteReady;
  logic [7:0] byteCount;
  logic [3:0] debug;

  nibble_entry #(
    .DEBOUNCE_CYCLES(Dc)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .switches  (switches),
    .enter     (enter),
    .clear     (clear),
    .nibbleData(nibbleData),
    .down      (down),
    .up        (up),
    .byteReady (byteReady),
    .byteCount (byteCount),
    .debug     (debug)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;  // 0 down, 1 up, 2 byteReady
    logic [3:0] nib;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   ready_seen = 0;
  logic prev_up = 1'b0;

  // Reference model: half-byte pending flag plus committed byte total.
  int   pending = 0;
  int   total = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_enter(input logic [3:0] val);
    exp_t e;
    e.nib = val;
    e.cnt = '0;
    if (pending == 0) begin
      e.kind = 0;
      q.push_back(e);
      pending = 1;
    end else begin
      e.kind = 1;
      q.push_back(e);
      total = (total + 1) % 256;
      e.kind = 2;
      e.cnt = 8'(total);
      q.push_back(e);
      pending = 0;
    end
  endtask

  // Clean hold long enough to debounce; release long enough to settle.
  task automatic press(input bit do_enter, input bit do_clear, input logic [3:0] val);
    switches = val;
    @(posedge clk); #1;
    if (do_clear) pending = 0;
    else if (do_enter) model_enter(val);
    enter = do_enter;
    clear = do_clear;
    repeat (Dc + 4) @(posedge clk);
    #1;
    enter = 1'b0;
    clear = 1'b0;
    repeat (Dc + 5) @(posedge clk);
    #1;
    check("debug_state", int'(debug), pending);
  endtask

  task automatic glitch(input int w);
    @(posedge clk); #1;
    enter = 1'b1;
    repeat (w) @(posedge clk);
    #1;
    enter = 1'b0;
    repeat (Dc + 3) @(posedge clk);
  endtask

  task automatic do_reset_check(input string tag);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check({tag, "_nibble"}, int'(nibbleData), 0);
    check({tag, "_strobes"}, int'({down, up, byteReady}), 0);
    check({tag, "_count"}, int'(byteCount), 0);
    check({tag, "_debug"}, int'(debug), 0);
    pending = 0;
    total = 0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   act;
    if (!rst && (down || up || byteReady)) begin
      check("single_strobe", int'(down) + int'(up) + int'(byteReady), 1);
      act = down ? 0 : (up ? 1 : 2);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual=kind%0d required=none t=%0t", act, $time);
      end else begin
        e = q.pop_front();
        check("strobe_kind", act, e.kind);
        if (act < 2) check("nibble", int'(nibbleData), int'(e.nib));
        else begin
          check("byte_count", int'(byteCount), int'(e.cnt));
          check("ready_after_up", int'(prev_up), 1);
        end
      end
      if (byteReady) ready_seen++;
    end
    prev_up = up;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("por_nibble", int'(nibbleData), 0);
    check("por_strobes", int'({down, up, byteReady}), 0);
    check("por_count", int'(byteCount), 0);
    check("por_debug", int'(debug), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Byte entry 0xA then 0x3
    press(1'b1, 1'b0, 4'hA);
    press(1'b1, 1'b0, 4'h3);
    check("byte1_count", int'(byteCount), 1);

    // Bounce: 2-cycle toggles never pass the debouncer
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      enter = ~enter;
      repeat (2) @(posedge clk);
      #1;
    end
    enter = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("bounce_debug", int'(debug), 0);
    // Then a clean hold: down lands exactly Dc+4 edges after the rise
    switches = 4'h5;
    repeat (3) @(posedge clk);
    #1;
    model_enter(4'h5);
    enter = 1'b1;
    repeat (Dc + 3) @(posedge clk);
    #1;
    check("down_not_early", int'(down), 0);
    @(posedge clk); #1;
    check("down_latency", int'(down), 1);
    repeat (2) @(posedge clk);
    #1;
    enter = 1'b0;
    repeat (Dc + 5) @(posedge clk);
    #1;
    check("after_hold_debug", int'(debug), 1);

    // Clear from HIGH discards the half byte
    press(1'b0, 1'b1, 4'h0);
    check("clear_count", int'(byteCount), 1);
    press(1'b1, 1'b0, 4'h9);
    press(1'b0, 1'b1, 4'h0);

    // Simultaneous enter+clear in LOW: clear wins
    press(1'b1, 1'b1, 4'h7);
    check("simul_count", int'(byteCount), 1);

    do_reset_check("async_rst");

    // Wrap: 256 bytes from zero
    ready_seen = 0;
    for (int i = 0; i < 256; i++) begin
      press(1'b1, 1'b0, 4'($urandom_range(0, 15)));
      press(1'b1, 1'b0, 4'($urandom_range(0, 15)));
    end
    check("wrap_count", int'(byteCount), 0);
    check("wrap_pulses", ready_seen, 256);

    // Random mix of presses, clears, coincident presses and short glitches
    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60) press(1'b1, 1'b0, 4'($urandom_range(0, 15)));
      else if (r < 75) press(1'b0, 1'b1, 4'($urandom_range(0, 15)));
      else if (r < 82) press(1'b1, 1'b1, 4'($urandom_range(0, 15)));
      else glitch($urandom_range(1, Dc - 1));
    end
    check("random_count", int'(byteCount), total);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_entry.md
# nibble_entry

Front-end input stage that drives the byte shifter. Synchronises and debounces two raw push-buttons (enter, clear), samples a 4-bit switch bank on each enter press, and emits the nibble with alternating one-cycle `down`/`up` strobes so the shifter assembles low then high nibble. After each completed byte it pulses `byteReady` and increments a byte counter, for the program loader / operator panel.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: cycles a synchronised button level must be stable before it is accepted; minimum 2.
- `CNT_W`, default $clog2(DEBOUNCE_CYCLES+1): debounce counter width, derived.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `switches`  in  4  raw nibble switches, asynchronous.
- `enter`  in  1  raw enter button, active-high, bouncing.
- `clear`  in  1  raw clear button, active-high, bouncing.
- `nibbleData`  out  4  registered nibble for shifter `dataIN`.
- `down`  out  1  one-cycle strobe: shifter loads low nibble.
- `up`  out  1  one-cycle strobe: shifter loads high nibble.
- `byteReady`  out  1  one-cycle pulse: shifter byte complete.
- `byteCount`  out  8  committed byte count, wraps.
- `debug`  out  4  current FSM state code.

## Operation
- Reset values: `nibbleData`=0, `down`=0, `up`=0, `byteReady`=0, `byteCount`=0, `debug`=0 (LOW); synchronisers, debounced levels, counters cleared.
- Per button: 2-flop synchroniser -> debouncer (counter clears whenever synced level equals debounced level; when counter reaches DEBOUNCE_CYCLES-1 and levels still differ, debounced level toggles and counter clears) -> registered rising-edge detect -> one-cycle press event. Releases produce no event.
- `switches` passes through a 2-flop synchroniser; the synced value is sampled on the press event.
- FSM states/codes: LOW=0, HIGH=1, COMMIT=2.
  - LOW + enter event: `nibbleData`<=switches, `down`<=1 next cycle, -> HIGH.
  - HIGH + enter event: `nibbleData`<=switches, `up`<=1 next cycle, -> COMMIT.
  - COMMIT: unconditional, `byteReady`<=1, `byteCount`<=byteCount+1 (255 wraps to 0), -> LOW.
  - Any state + clear event: -> LOW, no strobe, no count change; `nibbleData` holds.
- Simultaneous enter and clear events: clear wins, enter event discarded.
- Enter event in COMMIT: discarded (single cycle, button cannot re-press within debounce anyway).
- `down` and `up` never high in the same cycle; each high exactly one cycle per accepted press.

## Timing
- Raw button rise (held stable) to debounced level: DEBOUNCE_CYCLES+2 rising edges; press event 1 edge later; `down`/`up` and new `nibbleData` 1 edge after that (total DEBOUNCE_CYCLES+4).
- `nibbleData` and strobe change on the same edge, so the shifter captures the nibble on the following edge.
- `byteReady` high in the cycle after `up`, i.e. when shifter `dataOUT` already holds the new byte; `byteCount` updates on the same edge `byteReady` rises.
- Bounces shorter than DEBOUNCE_CYCLES produce no event.
- `rst` asserted mid-operation: all outputs return to reset values immediately (asynchronously); pending half-byte lost.

## Structure
- Shared package: state encoding constants (LOW/HIGH/COMMIT), DEBOUNCE_CYCLES default.
- One sub-module `debouncer` (synchroniser + counter + edge detect, parameter DEBOUNCE_CYCLES, outputs level and press pulse), instantiated twice.

## Test plan
All with DEBOUNCE_CYCLES=4.
- Reset: assert `rst` mid-cycle -> all outputs 0 without waiting for a clock edge, `debug`=0.
- Byte entry: switches=0xA, press enter; switches=0x3, press enter -> `down` one cycle with `nibbleData`=0xA, later `up` one cycle with 0x3, next cycle `byteReady`=1, `byteCount`=1, `debug` back to 0.
- Bounce: enter toggles every 2 cycles for 20 cycles then stays low -> no strobes; then held 10 cycles -> exactly one `down`, 8 edges after raw rise.
- Clear: one enter press (state HIGH), then clear press -> `debug`=0, no `up`/`byteReady`, `byteCount` unchanged; next enter gives `down`.
- Simultaneous: enter and clear raised on the same edge in LOW -> no strobe, state stays LOW.
- Wrap: 256 complete bytes -> `byteCount` returns to 0, 256 `byteReady` pulses.
